key_conditioner: RTL
====================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable clock cycles needed to accept a level change (20 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 key_start_n  input  1  raw board push-button, asynchronous; 0 means pressed.
REQ-005 key_si1_n  input  1  raw "serial 1" push-button, asynchronous; 0 means pressed.
REQ-006 key_si0_n  input  1  raw "serial 0" push-button, asynchronous; 0 means pressed.
REQ-007 start_pulse  output  1  single-cycle strobe, one per accepted start press.
REQ-008 bit_valid  output  1  single-cycle strobe, one per accepted data-bit press.
REQ-009 bit_value  output  1  data bit qualified by bit_valid: 1 for si_1, 0 for si_0.
REQ-010 conflict  output  1  single-cycle strobe when si_1 and si_0 presses are accepted in the same cycle.
REQ-011 keys_idle  output  1  high when all three channels are in the IDLE state.

Function
REQ-012 Each raw key shall pass through a two-flop synchronizer before any other use; the synchronizer resets to the released level (1).
REQ-013 Each channel shall run a 4-state FSM: IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
REQ-014 IDLE -> CONFIRM_PRESS when the synchronized key reads pressed; the counter clears to 0.
REQ-015 In CONFIRM_PRESS the counter increments each cycle while the key stays pressed; a released sample returns the FSM to IDLE with no pulse.
REQ-016 CONFIRM_PRESS -> HELD when the counter reaches DEBOUNCE_CYCLES-1 with the key still pressed; the channel's press pulse is high for exactly that transition cycle.
REQ-017 HELD -> CONFIRM_RELEASE when the key reads released; in CONFIRM_RELEASE a pressed sample returns the FSM to HELD with no new pulse, and DEBOUNCE_CYCLES-1 consecutive released cycles return it to IDLE.
REQ-018 Press latency: the pulse shall be high DEBOUNCE_CYCLES+2 clock edges after the first edge that samples the raw key low, with the raw key held low throughout.
REQ-019 A key held pressed indefinitely shall yield exactly one pulse, with no auto-repeat.
REQ-020 start_pulse = start channel pulse, registered with zero additional latency beyond REQ-018.
REQ-021 An si_1 pulse alone shall give bit_valid=1 and bit_value=1; an si_0 pulse alone shall give bit_valid=1 and bit_value=0.
REQ-022 Simultaneous si_1 and si_0 pulses shall give bit_valid=0 and conflict=1 for that cycle; bit_value shall hold its previous value.
REQ-023 A start pulse coincident with a bit pulse shall assert both start_pulse and bit_valid; downstream consumers resolve the priority.
REQ-024 The counter is 20 bits wide, saturates, and never wraps.
REQ-025 bit_value shall change only in cycles where bit_valid=1.

Reset
REQ-026 With rst_n=0: all FSMs in IDLE, counters 0, synchronizers 1, and start_pulse=0, bit_valid=0, bit_value=0, conflict=0, keys_idle=1.
REQ-027 Reset asserted mid-debounce or mid-hold shall abort the press with no pulse; after release of reset, a key still held shall be debounced afresh and pulse once.
REQ-028 Reset deassertion shall be synchronized internally by a two-flop release synchronizer.

Structure
REQ-029 The FSM state encoding and the default DEBOUNCE_CYCLES constant shall live in the shared project package.
REQ-030 One sub-module, key_debounce_ch (synchronizer, FSM, counter, and pulse), shall be instantiated three times; key_conditioner adds only the output combine logic of REQ-020 to REQ-023.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 key_si1_n held low for 20 cycles -> one bit_valid with bit_value=1 at edge 6 after the first low sample; no further pulses.
REQ-032 key_si0_n bouncing low 2, high 1, low 10 cycles -> exactly one bit_valid with bit_value=0, timed from the start of the final low run.
REQ-033 key_si1_n and key_si0_n pulled low on the same edge for 10 cycles -> conflict=1 for one cycle, bit_valid stays 0, bit_value unchanged.
REQ-034 key_start_n low for 10 cycles, then a 2-cycle high glitch, then low -> one start_pulse only; keys_idle=0 throughout.
REQ-035 rst_n pulsed low 2 cycles into a CONFIRM_PRESS with the key still held -> no pulse during reset; after reset releases, one pulse at DEBOUNCE_CYCLES+2 edges plus the reset-release synchronizer delay.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// Shared constants for the key conditioner: channel FSM encoding and debounce defaults.
package key_conditioner_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 1000000;
    localparam int unsigned CNT_W            = 20;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [1:0] ST_IDLE            = 2'd0;
    localparam logic [1:0] ST_CONFIRM_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD            = 2'd2;
    localparam logic [1:0] ST_CONFIRM_RELEASE = 2'd3;

endpackage

// File: rtl/key_conditioner_if.sv
// Raw push-button lines and conditioned strobes of the key conditioner.
interface key_conditioner_if;

    logic key_start_n;
    logic key_si1_n;
    logic key_si0_n;
    logic start_pulse;
    logic bit_valid;
    logic bit_value;
    logic conflict;
    logic keys_idle;

    modport master (
        output key_start_n, key_si1_n, key_si0_n,
        input  start_pulse, bit_valid, bit_value, conflict, keys_idle
    );

    modport slave (
        input  key_start_n, key_si1_n, key_si0_n,
        output start_pulse, bit_valid, bit_value, conflict, keys_idle
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One debounced push-button channel: reset-release sync, input sync, 4-state FSM,
// saturating confirm counter and a registered single-cycle press pulse.
//
// state              | meaning
// -------------------+------------------------------------------------------
// ST_IDLE            | key released and stable
// ST_CONFIRM_PRESS   | key reads pressed, counting stable pressed cycles
// ST_HELD            | press accepted (pulse issued), waiting for release
// ST_CONFIRM_RELEASE | key reads released, counting stable released cycles
module key_debounce_ch
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse,
    output logic idle
);

    // The compare fires on the edge where the count would reach DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       rst_pipe;
    logic             rst_int_n;
    logic [1:0]       key_sync;
    logic             pressed;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_int_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) key_sync <= 2'b11;
        else            key_sync <= {key_sync[0], key_n};
    end

    assign pressed = ~key_sync[1];
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign idle    = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pressed) begin
                        state <= ST_CONFIRM_PRESS;
                        cnt   <= '0;
                    end
                end
                ST_CONFIRM_PRESS: begin
                    if (!pressed) begin
                        state <= ST_IDLE;
                    end else if (cnt == TC) begin
                        state <= ST_HELD;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!pressed) begin
                        state <= ST_CONFIRM_RELEASE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (pressed) begin
                        state <= ST_HELD;
                    end else if (cnt == TC) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Three debounced key channels combined into start / data-bit / conflict strobes.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    key_conditioner_if.slave kif
);

    logic p_start, p_si1, p_si0;
    logic i_start, i_si1, i_si0;
    logic bit_value_q;
    logic bit_value_c;

    key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .rst_n(rst_n), .key_n(kif.key_start_n), .pulse(p_start), .idle(i_start)
    );

    key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_si1 (
        .clk(clk), .rst_n(rst_n), .key_n(kif.key_si1_n), .pulse(p_si1), .idle(i_si1)
    );

    key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_si0 (
        .clk(clk), .rst_n(rst_n), .key_n(kif.key_si0_n), .pulse(p_si0), .idle(i_si0)
    );

    // bit_value is presented in the same cycle as bit_valid and held otherwise.
    assign bit_value_c = (p_si1 ^ p_si0) ? p_si1 : bit_value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bit_value_q <= 1'b0;
        else        bit_value_q <= bit_value_c;
    end

    assign kif.start_pulse = p_start;
    assign kif.bit_valid   = p_si1 ^ p_si0;
    assign kif.conflict    = p_si1 & p_si0;
    assign kif.bit_value   = bit_value_c;
    assign kif.keys_idle   = i_start & i_si1 & i_si0;

endmodule
